// File: rtl/rr_index_encoder.sv
// Round-robin arbiter that encodes one of 16 request lines into a registered index plus valid.
// Optional grant timeout is compiled in with the RR_GRANT_TIMEOUT_EN macro.
module rr_index_encoder #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        ack,
  output logic [3:0]  binary_out,
  output logic        enable_out,
  output logic        timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] sel_idx;
  logic       sel_valid;

`ifdef RR_GRANT_TIMEOUT_EN
  // cnt_q holds the number of completed GRANT cycles that passed without ack.
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Rotating priority search: first set request at or after ptr_q, wrapping mod 16.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!sel_valid && req[4'(ptr_q + 4'(i))]) begin
        sel_valid = 1'b1;
        sel_idx   = 4'(ptr_q + 4'(i));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
`ifdef RR_GRANT_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = GRANT;
          idx_d   = sel_idx;
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (ack) begin
          state_d = IDLE;
          ptr_d   = 4'(idx_q + 4'd1);
        end else if (!req[idx_q]) begin
          // Requester went away: nothing was served, so the pointer stays put.
          state_d = IDLE;
`ifdef RR_GRANT_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = IDLE;
          ptr_d   = 4'(idx_q + 4'd1);
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = 8'(cnt_q + 8'd1);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    enable_out = (state_q == GRANT);
    binary_out = idx_q;
`ifdef RR_GRANT_TIMEOUT_EN
    timeout    = tmo_q;
`else
    timeout    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rr_index_encoder.sv
// Directed, table-driven bench for rr_index_encoder; timeout checks follow RR_GRANT_TIMEOUT_EN.
module tb_rr_index_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        ack;
  logic [3:0]  binary_out;
  logic        enable_out;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        ack;
    logic        en;
    logic [3:0]  bin;
    string       name;
  } vec_t;

  vec_t vecs[$];

  rr_index_encoder #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .binary_out (binary_out),
    .enable_out (enable_out),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic en, input logic [3:0] bin,
                            input logic tmo);
    check({name, ".enable_out"}, 16'(enable_out), 16'(en));
    check({name, ".binary_out"}, 16'(binary_out), 16'(bin));
    check({name, ".timeout"},    16'(timeout),    16'(tmo));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [15:0] q, input logic a,
                     input logic en, input logic [3:0] bin, input string name);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a; v.en = en; v.bin = bin; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    req = 16'hFFFF;
    ack = 1'b0;

    // Each row: inputs applied before an edge, outputs expected just after it.
    add(1, 16'hFFFF, 0, 0,  0, "rst_hold0");
    add(1, 16'hFFFF, 1, 0,  0, "rst_hold1");
    add(0, 16'h0020, 0, 1,  5, "basic_grant5");
    add(0, 16'h0020, 1, 0,  5, "basic_ack5");
    add(0, 16'h0000, 0, 0,  5, "idle_hold");
    add(0, 16'h0000, 1, 0,  5, "idle_ack_ignored");
    add(0, 16'h0061, 0, 1,  6, "ptr6_grant6");
    add(0, 16'h0061, 1, 0,  6, "ack6");
    add(0, 16'h0061, 0, 1,  0, "ptr7_wrap_grant0");
    add(0, 16'h0061, 1, 0,  0, "ack0");
    add(1, 16'h8001, 0, 0,  0, "rst_again");
    add(0, 16'h8001, 0, 1,  0, "rot_g0_a");
    add(0, 16'h8001, 1, 0,  0, "rot_gap_a");
    add(0, 16'h8001, 0, 1, 15, "rot_g15_a");
    add(0, 16'h8001, 1, 0, 15, "rot_gap_b");
    add(0, 16'h8001, 0, 1,  0, "rot_g0_b");
    add(0, 16'h8001, 1, 0,  0, "rot_gap_c");
    add(0, 16'h8001, 0, 1, 15, "rot_g15_b");
    add(0, 16'h8001, 1, 0, 15, "rot_gap_d");
    add(0, 16'h4000, 0, 1, 14, "wrap_pre_g14");
    add(0, 16'h4000, 1, 0, 14, "wrap_pre_ack");
    add(0, 16'h4003, 0, 1,  0, "wrap_g0");
    add(0, 16'h4003, 1, 0,  0, "wrap_ack0");
    add(0, 16'h4003, 0, 1,  1, "wrap_g1");
    add(0, 16'h4003, 1, 0,  1, "wrap_ack1");
    add(0, 16'h4003, 0, 1, 14, "wrap_g14");
    add(0, 16'h4003, 1, 0, 14, "wrap_ack14");
    add(0, 16'h0001, 0, 1,  0, "stable_g0");
    add(0, 16'h0003, 0, 1,  0, "stable_other_req");
    add(0, 16'hFFFF, 0, 1,  0, "stable_all_req");
    add(0, 16'h0001, 1, 0,  0, "stable_ack");
    add(0, 16'h0004, 0, 1,  2, "pre_wd_g2");
    add(0, 16'h0004, 1, 0,  2, "pre_wd_ack");
    add(0, 16'h0008, 0, 1,  3, "wd_g3");
    add(0, 16'h0000, 0, 0,  3, "wd_drop");
    add(0, 16'h000A, 0, 1,  3, "wd_search_from3");
    add(0, 16'h000A, 1, 0,  3, "wd_ack3");
    add(0, 16'h000A, 0, 1,  1, "both_g1");
    add(0, 16'h0008, 1, 0,  1, "both_ack_and_drop");
    add(0, 16'h000A, 0, 1,  3, "both_ptr2_g3");
    add(0, 16'h0000, 1, 0,  3, "both_ack3");

    #1;
    check_outs("rst_async_t0", 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      ack = vecs[i].ack;
      step();
      check_outs(vecs[i].name, vecs[i].en, vecs[i].bin, 1'b0);
    end

    // Reset in the middle of a grant drops enable_out without waiting for an edge.
    rst = 1'b0; req = 16'h0010; ack = 1'b0;
    step();
    check_outs("mid_g4", 1'b1, 4'd4, 1'b0);
    #2 rst = 1'b1;
    #1 check_outs("mid_rst_async", 1'b0, 4'd0, 1'b0);
    step();
    check_outs("mid_rst_edge", 1'b0, 4'd0, 1'b0);
    rst = 1'b0; req = 16'h00FF;
    step();
    check_outs("post_rst_ptr0", 1'b1, 4'd0, 1'b0);
    ack = 1'b1;
    step();
    check_outs("post_rst_ack", 1'b0, 4'd0, 1'b0);

    // Grant 7 with no ack.
    ack = 1'b0; req = 16'h0080;
    step();
    check_outs("to_g7", 1'b1, 4'd7, 1'b0);
`ifdef RR_GRANT_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("to_hold", 1'b1, 4'd7, 1'b0);
    end
    step();
    check_outs("to_revoke", 1'b0, 4'd7, 1'b1);
    req = 16'h0180;
    step();
    check_outs("to_next_g8", 1'b1, 4'd8, 1'b0);
    ack = 1'b1;
    step();
    check_outs("to_ack8", 1'b0, 4'd8, 1'b0);
    ack = 1'b0; req = 16'h0080;
    step();
    check_outs("to_g7_again", 1'b1, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("to_hold_again", 1'b1, 4'd7, 1'b0);
    end
    ack = 1'b1;
    step();
    check_outs("to_ack_on_expiry", 1'b0, 4'd7, 1'b0);
    ack = 1'b0; req = 16'h0180;
    step();
    check_outs("to_after_ack_g8", 1'b1, 4'd8, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      check_outs("hold_no_timeout", 1'b1, 4'd7, 1'b0);
    end
    ack = 1'b1;
    step();
    check_outs("hold_ack7", 1'b0, 4'd7, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
